// File: rtl/estagio_operandos_pkg.sv
// Shared constants for the operand-fetch stage: data/address widths and
// the 4-bit ALU operation codes forwarded to the execute stage.
package estagio_operandos_pkg;

    localparam int LARGURA_DADO    = 32;
    localparam int LARGURA_END     = 4;
    localparam int NUM_REGS_PADRAO = 16;
    localparam int LARGURA_IMED    = 16;

    typedef enum logic [LARGURA_END-1:0] {
        SOMA  = 4'b0000,
        SUB   = 4'b0001,
        MUL   = 4'b0010,
        DIV   = 4'b0011,
        RESTO = 4'b0100,
        E     = 4'b0101,
        OU    = 4'b0110,
        NAO   = 4'b0111,
        XOU   = 4'b1000,
        SHR   = 4'b1001,
        SHL   = 4'b1010,
        IGUAL = 4'b1011,
        MAIOR = 4'b1100,
        MENOR = 4'b1101,
        AUX   = 4'b1110
    } op_ula_t;

    // Output register occupancy: VAZIO means saida_valida=0.
    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

endpackage

// File: rtl/estagio_operandos_if.sv
// Instruction-in / operands-out handshake bundle of the operand stage.
// master = surrounding pipeline, slave = estagio_operandos.
interface estagio_operandos_if
    import estagio_operandos_pkg::*;
#(
    parameter int LARGURA = LARGURA_DADO
);
    logic                    instr_valido;
    logic                    instr_pronto;
    logic [LARGURA_END-1:0]  comando_in;
    logic [LARGURA_END-1:0]  rs1;
    logic [LARGURA_END-1:0]  rs2;
    logic [LARGURA_END-1:0]  rd_in;
    logic                    usa_imediato;
    logic [LARGURA_IMED-1:0] imediato;

    logic                    saida_valida;
    logic                    ula_pronta;
    logic [LARGURA_END-1:0]  comando;
    logic [LARGURA_END-1:0]  rd_out;
    logic [LARGURA-1:0]      entrada1;
    logic [LARGURA-1:0]      entrada2;

    modport master (
        output instr_valido, comando_in, rs1, rs2, rd_in, usa_imediato, imediato, ula_pronta,
        input  instr_pronto, saida_valida, comando, rd_out, entrada1, entrada2
    );

    modport slave (
        input  instr_valido, comando_in, rs1, rs2, rd_in, usa_imediato, imediato, ula_pronta,
        output instr_pronto, saida_valida, comando, rd_out, entrada1, entrada2
    );

endinterface

// File: rtl/estagio_operandos_banco_registradores.sv
// Register file: NUM_REGS x LARGURA, two combinational read ports, one
// write port. R0 is hard-wired to zero.
module banco_registradores
    import estagio_operandos_pkg::*;
#(
    parameter int LARGURA  = LARGURA_DADO,
    parameter int NUM_REGS = NUM_REGS_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LARGURA_END-1:0] end_leitura1,
    input  logic [LARGURA_END-1:0] end_leitura2,
    output logic [LARGURA-1:0]     dado_leitura1,
    output logic [LARGURA-1:0]     dado_leitura2,
    input  logic                   escrita_hab,
    input  logic [LARGURA_END-1:0] escrita_end,
    input  logic [LARGURA-1:0]     escrita_dado
);

    logic [LARGURA-1:0] regs [NUM_REGS];

    // NOTE: this array is reset on purpose (a cleared register file is part of
    // the reset contract), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (escrita_hab && (escrita_end != '0)) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples values from before this edge.
            regs[escrita_end] <= escrita_dado;
        end
    end

    assign dado_leitura1 = (end_leitura1 == '0) ? '0 : regs[end_leitura1];
    assign dado_leitura2 = (end_leitura2 == '0) ? '0 : regs[end_leitura2];

endmodule

// File: rtl/estagio_operandos.sv
// Operand-fetch stage: reads two sources (with writeback bypass), selects
// the immediate, and presents registered operands through a valid/ready pair.
module estagio_operandos
    import estagio_operandos_pkg::*;
#(
    parameter int LARGURA  = LARGURA_DADO,
    parameter int NUM_REGS = NUM_REGS_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    estagio_operandos_if.slave     bus,
    input  logic                   escrita_hab,
    input  logic [LARGURA_END-1:0] escrita_end,
    input  logic [LARGURA-1:0]     escrita_dado
);

    estado_t            estado;
    estado_t            prox_estado;
    logic               aceita;
    logic [LARGURA-1:0] leitura1;
    logic [LARGURA-1:0] leitura2;
    logic [LARGURA-1:0] operando1;
    logic [LARGURA-1:0] operando2;
    logic [LARGURA-1:0] imediato_ext;

    banco_registradores #(
        .LARGURA  (LARGURA),
        .NUM_REGS (NUM_REGS)
    ) u_banco (
        .clock         (clock),
        .reset         (reset),
        .end_leitura1  (bus.rs1),
        .end_leitura2  (bus.rs2),
        .dado_leitura1 (leitura1),
        .dado_leitura2 (leitura2),
        .escrita_hab   (escrita_hab),
        .escrita_end   (escrita_end),
        .escrita_dado  (escrita_dado)
    );

    // Bypass: a writeback landing this cycle is visible to the reader now,
    // except for R0 which stays zero regardless.
    assign operando1 = (bus.rs1 == '0) ? '0 :
                       (escrita_hab && (escrita_end == bus.rs1)) ? escrita_dado : leitura1;
    assign operando2 = (bus.rs2 == '0) ? '0 :
                       (escrita_hab && (escrita_end == bus.rs2)) ? escrita_dado : leitura2;

    assign imediato_ext = {{(LARGURA - LARGURA_IMED){bus.imediato[LARGURA_IMED-1]}}, bus.imediato};

    assign bus.saida_valida = (estado == CHEIO);
    assign bus.instr_pronto = !bus.saida_valida || bus.ula_pronta;
    assign aceita           = bus.instr_valido && bus.instr_pronto;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= VAZIO;
        end else begin
            estado <= prox_estado;
        end
    end

    // NOTE: prox_estado gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        prox_estado = estado;
        case (estado)
            VAZIO:   if (aceita) prox_estado = CHEIO;
            CHEIO:   if (bus.ula_pronta && !bus.instr_valido) prox_estado = VAZIO;
            default: prox_estado = VAZIO;
        endcase
    end

    // Operand registers only move on accept, so they hold under backpressure
    // and keep the last loaded values while the stage is empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.comando  <= SOMA;
            bus.rd_out   <= '0;
            bus.entrada1 <= '0;
            bus.entrada2 <= '0;
        end else if (aceita) begin
            bus.comando  <= bus.comando_in;
            bus.rd_out   <= bus.rd_in;
            bus.entrada1 <= operando1;
            bus.entrada2 <= bus.usa_imediato ? imediato_ext : operando2;
        end
    end

endmodule

// File: tb/tb_estagio_operandos.sv
// Self-checking bench for estagio_operandos: per-cycle comparison against a
// behavioural model, plus directed literal checks and randomized traffic.
module tb_estagio_operandos;
    import estagio_operandos_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        escrita_hab;
    logic [3:0]  escrita_end;
    logic [31:0] escrita_dado;

    estagio_operandos_if #(.LARGURA(32)) bus ();

    estagio_operandos #(.LARGURA(32), .NUM_REGS(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .escrita_hab  (escrita_hab),
        .escrita_end  (escrita_end),
        .escrita_dado (escrita_dado)
    );

    always #50 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit compara = 1'b0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
        end
    endtask

    // Behavioural model: architectural registers plus the single output slot.
    logic [31:0] m_regs [16];
    logic        m_valida;
    logic [3:0]  m_cmd;
    logic [3:0]  m_rd;
    logic [31:0] m_e1;
    logic [31:0] m_e2;

    function automatic logic [31:0] m_le(input logic [3:0] a);
        if (a == 4'd0) return 32'd0;
        if (escrita_hab && escrita_end == a) return escrita_dado;
        return m_regs[a];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
            m_valida <= 1'b0;
            m_cmd    <= 4'd0;
            m_rd     <= 4'd0;
            m_e1     <= 32'd0;
            m_e2     <= 32'd0;
        end else begin
            if (bus.instr_valido && (!m_valida || bus.ula_pronta)) begin
                m_valida <= 1'b1;
                m_cmd    <= bus.comando_in;
                m_rd     <= bus.rd_in;
                m_e1     <= m_le(bus.rs1);
                m_e2     <= bus.usa_imediato ? 32'($signed(bus.imediato)) : m_le(bus.rs2);
            end else if (bus.ula_pronta) begin
                m_valida <= 1'b0;
            end
            if (escrita_hab && escrita_end != 4'd0) m_regs[escrita_end] <= escrita_dado;
        end
    end

    always @(negedge clock) begin
        if (compara && !reset) begin
            check("pronto",   32'(bus.instr_pronto), 32'(!m_valida || bus.ula_pronta));
            check("valida",   32'(bus.saida_valida), 32'(m_valida));
            check("comando",  32'(bus.comando), 32'(m_cmd));
            check("rd_out",   32'(bus.rd_out), 32'(m_rd));
            check("entrada1", bus.entrada1, m_e1);
            check("entrada2", bus.entrada2, m_e2);
        end
    end

    task automatic tick();
        @(posedge clock);
        #5;
    endtask

    task automatic instr(input logic v, input logic [3:0] cmd, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] rd, input logic ui,
                         input logic [15:0] imm);
        bus.instr_valido = v;
        bus.comando_in   = cmd;
        bus.rs1          = a1;
        bus.rs2          = a2;
        bus.rd_in        = rd;
        bus.usa_imediato = ui;
        bus.imediato     = imm;
    endtask

    task automatic wb(input logic h, input logic [3:0] a, input logic [31:0] d);
        escrita_hab  = h;
        escrita_end  = a;
        escrita_dado = d;
    endtask

    initial begin
        instr(1'b0, SOMA, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
        bus.ula_pronta = 1'b1;
        wb(1'b0, 4'd0, 32'd0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #5;
        check("rst_valida",   32'(bus.saida_valida), 32'd0);
        check("rst_comando",  32'(bus.comando), 32'd0);
        check("rst_rd",       32'(bus.rd_out), 32'd0);
        check("rst_entrada1", bus.entrada1, 32'd0);
        check("rst_entrada2", bus.entrada2, 32'd0);
        check("rst_pronto",   32'(bus.instr_pronto), 32'd1);
        reset   = 1'b0;
        compara = 1'b1;

        // R0 write must be ignored, also on the bypass path.
        wb(1'b1, 4'd0, 32'hFFFF_FFFF);
        tick();
        instr(1'b1, SOMA, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0);
        tick();
        check("r0_entrada1", bus.entrada1, 32'd0);
        check("r0_entrada2", bus.entrada2, 32'd0);
        check("r0_valida",   32'(bus.saida_valida), 32'd1);

        // Bypass of a same-cycle writeback.
        wb(1'b1, 4'd5, 32'h1234_5678);
        instr(1'b1, SUB, 4'd5, 4'd5, 4'd3, 1'b0, 16'h0);
        tick();
        check("byp_entrada1", bus.entrada1, 32'h1234_5678);
        check("byp_entrada2", bus.entrada2, 32'h1234_5678);
        check("byp_comando",  32'(bus.comando), 32'd1);
        check("byp_rd",       32'(bus.rd_out), 32'd3);

        // Sign-extended immediate.
        wb(1'b0, 4'd0, 32'd0);
        instr(1'b1, SOMA, 4'd5, 4'd0, 4'd2, 1'b1, 16'h8001);
        tick();
        check("imm_entrada2", bus.entrada2, 32'hFFFF_8001);
        check("imm_comando",  32'(bus.comando), 32'd0);
        check("imm_entrada1", bus.entrada1, 32'h1234_5678);

        // Backpressure: three stalled cycles, then the waiting instruction loads.
        bus.ula_pronta = 1'b0;
        instr(1'b1, XOU, 4'd5, 4'd0, 4'd9, 1'b1, 16'h0007);
        #1 check("bp_pronto0", 32'(bus.instr_pronto), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_pronto",   32'(bus.instr_pronto), 32'd0);
            check("bp_hold_e2",  bus.entrada2, 32'hFFFF_8001);
            check("bp_hold_cmd", 32'(bus.comando), 32'd0);
            check("bp_hold_rd",  32'(bus.rd_out), 32'd2);
        end
        bus.ula_pronta = 1'b1;
        #1 check("bp_pronto1", 32'(bus.instr_pronto), 32'd1);
        tick();
        check("bp_load_cmd", 32'(bus.comando), 32'd8);
        check("bp_load_e2",  bus.entrada2, 32'h0000_0007);
        check("bp_load_rd",  32'(bus.rd_out), 32'd9);
        check("bp_valida",   32'(bus.saida_valida), 32'd1);

        // Eight back-to-back instructions, one per cycle, in order.
        for (int i = 0; i < 8; i++) begin
            instr(1'b1, 4'(i), 4'd0, 4'd0, 4'(i + 4), 1'b1, 16'(i * 3));
            tick();
            check("str_valida", 32'(bus.saida_valida), 32'd1);
            check("str_rd",     32'(bus.rd_out), 32'(i + 4));
            check("str_e2",     bus.entrada2, 32'(i * 3));
        end
        instr(1'b0, SOMA, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
        tick();
        check("str_drain", 32'(bus.saida_valida), 32'd0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 400; n++) begin
            instr(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom), 16'($urandom));
            bus.ula_pronta = ($urandom % 3) != 0;
            wb(1'($urandom), 4'($urandom), $urandom);
            tick();
        end

        // Fill R1..R15 with known values, reading each through the bypass.
        bus.ula_pronta = 1'b1;
        for (int i = 1; i < 16; i++) begin
            wb(1'b1, 4'(i), 32'hA000_0000 + 32'(i));
            instr(1'b1, ADD_CMD(i), 4'(i), 4'(i - 1), 4'(i), 1'b0, 16'h0);
            tick();
            check("fill_e1", bus.entrada1, 32'hA000_0000 + 32'(i));
            check("fill_e2", bus.entrada2, (i == 1) ? 32'd0 : 32'hA000_0000 + 32'(i - 1));
        end
        wb(1'b0, 4'd0, 32'd0);

        // Asynchronous reset between edges with a held instruction.
        instr(1'b1, MUL, 4'd3, 4'd4, 4'd6, 1'b0, 16'h0);
        tick();
        check("pre_rst_valida", 32'(bus.saida_valida), 32'd1);
        #10 reset = 1'b1;
        #1;
        check("arst_valida",   32'(bus.saida_valida), 32'd0);
        check("arst_entrada1", bus.entrada1, 32'd0);
        check("arst_entrada2", bus.entrada2, 32'd0);
        check("arst_comando",  32'(bus.comando), 32'd0);
        check("arst_rd",       32'(bus.rd_out), 32'd0);
        for (int i = 1; i < 16; i++) begin
            bus.rs1 = 4'(i);
            #1 check("arst_reg", dut.leitura1, 32'd0);
        end
        instr(1'b1, MAIOR, 4'd7, 4'd0, 4'd4, 1'b1, 16'h1234);
        #2 reset = 1'b0;
        tick();
        check("post_rst_valida", 32'(bus.saida_valida), 32'd1);
        check("post_rst_cmd",    32'(bus.comando), 32'd12);
        check("post_rst_e1",     bus.entrada1, 32'd0);
        check("post_rst_e2",     bus.entrada2, 32'h0000_1234);

        instr(1'b0, SOMA, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [3:0] ADD_CMD(input int i);
        return 4'(i % 15);
    endfunction

endmodule

// File: doc/estagio_operandos.md
ESTAGIO_OPERANDOS -- requirements
Module: estagio_operandos

Interface
REQ-001 Parameter LARGURA, default 32: data width of registers and operands.
REQ-002 Parameter NUM_REGS, default 16: register count; address width is 4 bits.
REQ-003 Port clock, in, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-high reset.
REQ-005 Port instr_valido, in, 1: upstream instruction present this cycle.
REQ-006 Port instr_pronto, out, 1: stage accepts the instruction this cycle.
REQ-007 Port comando_in, in, 4: ALU operation code to forward.
REQ-008 Port rs1 / rs2 / rd_in, in, 4 each: source and destination register addresses.
REQ-009 Port usa_imediato, in, 1: select the immediate instead of rs2 for operand 2.
REQ-010 Port imediato, in, 16: immediate, two's-complement.
REQ-011 Port escrita_hab, in, 1: writeback write enable.
REQ-012 Port escrita_end, in, 4: writeback address.
REQ-013 Port escrita_dado, in, LARGURA: writeback data.
REQ-014 Port saida_valida, out, 1: registered operands valid for the ALU.
REQ-015 Port ula_pronta, in, 1: downstream consumes the current operands.
REQ-016 Port comando / rd_out, out, 4 each: registered ALU code and destination.
REQ-017 Port entrada1 / entrada2, out, LARGURA: registered ALU operands.

Function
REQ-018 Register file SHALL hold NUM_REGS x LARGURA; R0 SHALL always read 0, and writes to R0 SHALL be ignored.
REQ-019 Write SHALL occur on the clock edge when escrita_hab=1.
REQ-020 Reads SHALL be combinational with bypass: when escrita_hab=1, escrita_end==rsX and rsX!=0, the read SHALL return escrita_dado in the same cycle.
REQ-021 Operand 2 SHALL be {16{imediato[15]},imediato} when usa_imediato=1, else the rs2 read.
REQ-022 instr_pronto SHALL equal !saida_valida || ula_pronta (combinational).
REQ-023 Accept = instr_valido && instr_pronto; on accept, comando, rd_out, entrada1 and entrada2 SHALL load at the next edge and saida_valida SHALL be 1, giving 1-cycle latency.
REQ-024 Without accept, and with ula_pronta=1, saida_valida SHALL go to 0 at the next edge.
REQ-025 While saida_valida=1 and ula_pronta=0, all outputs SHALL hold stable and no instruction SHALL be accepted.
REQ-026 Simultaneous accept and ula_pronta=1 SHALL replace the outputs with no bubble, sustaining one instruction per cycle.
REQ-027 Outputs SHALL be ignored by downstream while saida_valida=0; their contents then are the last loaded values.
REQ-028 Valid/ready state machine SHALL have two states, VAZIO (saida_valida=0) and CHEIO (saida_valida=1): VAZIO->CHEIO on accept; CHEIO->VAZIO on ula_pronta && !instr_valido; all other cases stay.

Reset
REQ-029 reset SHALL immediately clear all registers R0..R15, saida_valida, entrada1, entrada2, comando (0000) and rd_out to 0, independent of clock.
REQ-030 Reset mid-operation SHALL discard any held instruction; the first accept is allowed on the first edge after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the 4-bit ALU operation constants, as follows:
- SOMA 0000, SUB 0001, MUL 0010, DIV 0011, RESTO 0100
- E 0101, OU 0110, NAO 0111, XOU 1000
- SHR 1001, SHL 1010, IGUAL 1011, MAIOR 1100, MENOR 1101, AUX 1110
REQ-032 The same shared package SHALL hold the LARGURA and address-width constants.
REQ-033 The register file SHALL be one sub-module, banco_registradores, with 2 read ports and 1 write port; handshake and bypass SHALL live in estagio_operandos.

Verification
REQ-034 Reset and R0 check: write R0=0xFFFFFFFF, then issue rs1=0 -> entrada1=0, saida_valida=1 one cycle after accept.
REQ-035 Bypass check: escrita_hab=1, R5<=0x12345678 in the same cycle as accepting rs1=5 -> entrada1=0x12345678.
REQ-036 Immediate check: usa_imediato=1, imediato=0x8001, comando_in=0000 -> entrada2=0xFFFF8001, comando=0000.
REQ-037 Backpressure check: ula_pronta=0 for 3 cycles with instr_valido=1 -> instr_pronto=0 and outputs unchanged; when ula_pronta=1, the next instruction loads with no bubble.
REQ-038 Streaming check: 8 back-to-back instructions with ula_pronta=1 -> 8 consecutive valid cycles, in order.
REQ-039 Async reset check: assert reset mid-stream between edges -> saida_valida=0 and R1..R15 read 0 before the next edge.
